// File: rtl/audio_sdm_dac_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : audio_sdm_dac_pkg
//  Brief    : Shared synth audio constants, LFSR settings and DAC state type.
//  Revision : 1.0 - initial release
// ============================================================================
package audio_sdm_dac_pkg;

    localparam int          SYNTH_W    = 18;
    localparam logic [17:0] MIDSCALE   = 18'h20000;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1 -> register bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } dac_state_t;

endpackage : audio_sdm_dac_pkg
`default_nettype wire

// File: rtl/audio_sdm_dac_sdm_mod1.sv
`default_nettype none
// ============================================================================
//  Module   : sdm_mod1
//  Brief    : First-order sigma-delta modulator with optional LFSR dither
//             (enabled by defining SDM_DITHER_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module sdm_mod1
    import audio_sdm_dac_pkg::*;
#(
    parameter int W = SYNTH_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_level,
    output logic         o_pdm
);

    logic [W-1:0] w_level;
    logic [W:0]   w_sum;
    logic [W-1:0] r_acc;
    logic         r_pdm;

`ifdef SDM_DITHER_EN
    logic [15:0]        r_lfsr;
    logic               w_fb;
    logic signed [4:0]  w_off;
    logic signed [W+1:0] w_dsum;

    assign w_fb   = ^(r_lfsr & LFSR_TAPS);
    assign w_off  = $signed({1'b0, r_lfsr[3:0]}) - 5'sd8;
    assign w_dsum = $signed({2'b00, i_level}) + (W+2)'(w_off);

    always_comb begin
        w_level = w_dsum[W-1:0];
        if (w_dsum[W+1]) begin
            w_level = '0;
        end else if (w_dsum[W]) begin
            w_level = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end
`else
    assign w_level = i_level;
`endif

    // The accumulator carry is the PDM bit; it lives in r_pdm rather than acc.
    assign w_sum = {1'b0, r_acc} + {1'b0, w_level};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_pdm <= 1'b0;
        end else begin
            r_acc <= w_sum[W-1:0];
            r_pdm <= w_sum[W];
        end
    end

    assign o_pdm = r_pdm;

endmodule : sdm_mod1
`default_nettype wire

// File: rtl/audio_sdm_dac.sv
`default_nettype none
// ============================================================================
//  Module   : audio_sdm_dac
//  Brief    : Sample handshake, linear interpolator, underrun monitor and
//             1-bit sigma-delta output. SDM_DITHER_EN adds LFSR dither.
//  Revision : 1.0 - initial release
// ============================================================================
module audio_sdm_dac
    import audio_sdm_dac_pkg::*;
#(
    parameter int W         = SYNTH_W,
    parameter int RAMP_LOG2 = 4,
    parameter int TIMEOUT   = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sample_in,
    input  logic         sample_valid,
    output logic         sample_ready,
    input  logic         underrun_clr,
    output logic         underrun,
    output logic         pdm_out
);

    localparam int                c_CW      = W + RAMP_LOG2;
    localparam int                c_IW      = $clog2(TIMEOUT + 1);
    localparam logic [c_IW-1:0]   c_TO      = c_IW'(TIMEOUT);
    localparam logic [W-1:0]      c_MID     = {1'b1, {(W-1){1'b0}}};
    localparam logic [c_CW-1:0]   c_CUR_RST = {c_MID, {RAMP_LOG2{1'b0}}};

    dac_state_t             r_state;
    dac_state_t             w_state_nxt;
    logic [W-1:0]           r_target;
    logic signed [W:0]      r_delta;
    logic signed [W:0]      w_delta_nxt;
    logic [c_CW-1:0]        w_delta_ext;
    logic [c_CW-1:0]        r_cur;
    logic [W-1:0]           w_cur_int;
    logic [RAMP_LOG2-1:0]   r_ramp_cnt;
    logic [c_IW-1:0]        r_idle_cnt;
    logic                   r_underrun;
    logic                   w_accept;
    logic                   w_idle;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_accept    = sample_valid && w_idle;
    assign w_cur_int   = r_cur[c_CW-1:RAMP_LOG2];
    assign w_delta_nxt = $signed({1'b0, sample_in}) - $signed({1'b0, w_cur_int});
    assign w_delta_ext = c_CW'(r_delta);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (sample_valid)  w_state_nxt = ST_RAMP;
            ST_RAMP: if (&r_ramp_cnt)   w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sample_ready = (r_state == ST_IDLE);
    end

    // Interpolator: fractional accumulation, then snap exactly onto target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_target   <= c_MID;
            r_delta    <= '0;
            r_ramp_cnt <= '0;
            r_cur      <= c_CUR_RST;
        end else if (w_accept) begin
            r_target   <= sample_in;
            r_delta    <= w_delta_nxt;
            r_ramp_cnt <= '0;
        end else if (r_state == ST_RAMP) begin
            r_ramp_cnt <= r_ramp_cnt + 1'b1;
            if (&r_ramp_cnt) begin
                r_cur <= {r_target, {RAMP_LOG2{1'b0}}};
            end else begin
                r_cur <= r_cur + w_delta_ext;
            end
        end
    end

    // Underrun sets only on the transition into timeout so a clear sticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle_cnt <= '0;
            r_underrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_idle_cnt <= '0;
            end else if (w_idle && (r_idle_cnt != c_TO)) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end

            if (w_idle && !w_accept && (r_idle_cnt == c_TO - 1'b1)) begin
                r_underrun <= 1'b1;
            end else if (underrun_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign underrun = r_underrun;

    sdm_mod1 #(
        .W (W)
    ) u_sdm (
        .clk     (clk),
        .rst     (rst),
        .i_level (w_cur_int),
        .o_pdm   (pdm_out)
    );

endmodule : audio_sdm_dac
`default_nettype wire

// File: tb/tb_audio_sdm_dac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_audio_sdm_dac
//  Brief    : Directed self-checking bench for audio_sdm_dac (default build).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_audio_sdm_dac;

    logic        clk;
    logic        rst;
    logic [17:0] sample_in;
    logic        sample_valid;
    logic        underrun_clr;
    wire         sample_ready;
    wire         underrun;
    wire         pdm_out;
    wire  [17:0] cur_int;

    int tests;
    int fails;

    audio_sdm_dac #(
        .W         (18),
        .RAMP_LOG2 (4),
        .TIMEOUT   (4096)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .underrun_clr (underrun_clr),
        .underrun     (underrun),
        .pdm_out      (pdm_out)
    );

    assign cur_int = dut.r_cur[21:4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sample_valid = 1'b0; underrun_clr = 1'b0; sample_in = '0;
        @(negedge clk);
        @(negedge clk);
        tests++; if (sample_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", sample_ready); end
        tests++; if (cur_int !== 18'h20000) begin fails++; $display("FAIL reset_cur got %h want 20000", cur_int); end
        tests++; if (pdm_out !== 1'b0) begin fails++; $display("FAIL reset_pdm got %b want 0", pdm_out); end
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun got %b want 0", underrun); end
        rst = 1'b0;
    endtask

    task automatic test_midscale();
        int ones = 0;
        int alt_err = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (pdm_out === 1'b1) ones++;
            if (pdm_out !== 1'(i & 1)) alt_err++;
        end
        tests++; if (ones != 32) begin fails++; $display("FAIL mid_ones got %0d want 32", ones); end
        tests++; if (alt_err != 0) begin fails++; $display("FAIL mid_alternate got %0d bad bits want 0", alt_err); end
        tests++; if (sample_ready !== 1'b1) begin fails++; $display("FAIL mid_ready got %b want 1", sample_ready); end
    endtask

    task automatic test_ramp_up();
        int ones = 0;
        logic [17:0] exp_cur;
        tests++; if (sample_ready !== 1'b1) begin fails++; $display("FAIL up_ready_pre got %b want 1", sample_ready); end
        sample_in = 18'h30000; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            exp_cur = 18'h20000 + 18'((k - 1) * 18'h01000);
            tests++; if (sample_ready !== 1'b0) begin fails++; $display("FAIL up_ready_low k=%0d got %b want 0", k, sample_ready); end
            tests++; if (cur_int !== exp_cur) begin fails++; $display("FAIL up_step k=%0d got %h want %h", k, cur_int, exp_cur); end
            @(negedge clk);
        end
        tests++; if (sample_ready !== 1'b1) begin fails++; $display("FAIL up_ready_post got %b want 1", sample_ready); end
        tests++; if (cur_int !== 18'h30000) begin fails++; $display("FAIL up_final got %h want 30000", cur_int); end
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (pdm_out === 1'b1) ones++;
        end
        tests++; if (ones != 768) begin fails++; $display("FAIL up_ones got %0d want 768", ones); end
    endtask

    task automatic test_rst_mid_ramp();
        sample_in = 18'h3F000; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (5) @(negedge clk);
        tests++; if (sample_ready !== 1'b0) begin fails++; $display("FAIL rstmid_inramp got %b want 0", sample_ready); end
        #1 rst = 1'b1;
        #1;
        tests++; if (sample_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready got %b want 1", sample_ready); end
        tests++; if (cur_int !== 18'h20000) begin fails++; $display("FAIL rstmid_cur got %h want 20000", cur_int); end
        tests++; if (pdm_out !== 1'b0) begin fails++; $display("FAIL rstmid_pdm got %b want 0", pdm_out); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ramp_down();
        int ones = 0;
        sample_in = 18'h00000; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (8) @(negedge clk);
        tests++; if (cur_int !== 18'h10000) begin fails++; $display("FAIL down_mid got %h want 10000", cur_int); end
        repeat (8) @(negedge clk);
        tests++; if (cur_int !== 18'h00000) begin fails++; $display("FAIL down_final got %h want 00000", cur_int); end
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (pdm_out !== 1'b0) ones++;
        end
        tests++; if (ones != 0) begin fails++; $display("FAIL down_pdm_ones got %0d want 0", ones); end
    endtask

    task automatic test_back_to_back();
        logic [17:0] v;
        logic        exp_rdy;
        for (int i = 0; i <= 34; i++) begin
            exp_rdy = ((i % 17) == 0);
            tests++; if (sample_ready !== exp_rdy) begin fails++; $display("FAIL b2b_ready i=%0d got %b want %b", i, sample_ready, exp_rdy); end
            if (i == 17) begin
                tests++; if (cur_int !== 18'h10000) begin fails++; $display("FAIL b2b_first got %h want 10000", cur_int); end
            end
            if (i == 34) begin
                tests++; if (cur_int !== 18'h18800) begin fails++; $display("FAIL b2b_second got %h want 18800", cur_int); end
            end
            if (i < 34) begin
                v = 18'h10000 + 18'(i * 18'h00800);
                sample_in = v; sample_valid = 1'b1;
                @(negedge clk);
            end
        end
        sample_valid = 1'b0;
    endtask

    task automatic test_underrun();
        do_reset();
        repeat (4095) @(negedge clk);
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL ur_early got %b want 0", underrun); end
        @(negedge clk);
        tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL ur_set got %b want 1", underrun); end
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL ur_clear got %b want 0", underrun); end
        sample_in = 18'h20000; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (4111) @(negedge clk);
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL ur_early2 got %b want 0", underrun); end
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL ur_set_wins got %b want 1", underrun); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        sample_in = '0;
        sample_valid = 1'b0;
        underrun_clr = 1'b0;
        test_reset();
        test_midscale();
        test_ramp_up();
        test_rst_mid_ramp();
        test_ramp_down();
        test_back_to_back();
        test_underrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_audio_sdm_dac
`default_nettype wire
